// File: rtl/avalon_st_source_interface.sv
// Avalon-ST source stage: tags RGB565 pixels with sop/eop from a raster counter and
// drives them downstream through a 2-entry skid buffer (OUT + SKID) so that both the
// upstream ready and the downstream valid/data are registered.
module avalon_st_source_interface #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FRAME_W = 320,
    parameter int unsigned FRAME_H = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid_in,
    input  logic [DATA_W-1:0] pix_data_in,
    output logic              pix_ready_out,
    input  logic              frame_sync,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out
);

    // Counter widths; a 1-pixel dimension still needs a 1-bit counter.
    localparam int unsigned XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam logic [XW-1:0] LastX = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] LastY = YW'(FRAME_H - 1);

    // Raster position of the next pixel to be accepted
    logic [XW-1:0] x_q, x_d, x_base;
    logic [YW-1:0] y_q, y_d, y_base;

    // Registered upstream ready
    logic ready_q, ready_d;

    // Output register
    logic              out_full_q, out_full_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;

    // Skid register
    logic              skid_full_q, skid_full_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_sop_q, skid_sop_d;
    logic              skid_eop_q, skid_eop_d;

    logic accept;
    logic send;
    logic tag_sop;
    logic tag_eop;

    // Handshake qualifiers on both sides
    always_comb begin
        accept = pix_valid_in & ready_q;
        send   = out_full_q & ready_in;
    end

    // Tagging and raster counter; frame_sync rebases the position to (0,0) first
    always_comb begin
        x_base  = frame_sync ? '0 : x_q;
        y_base  = frame_sync ? '0 : y_q;
        tag_sop = (x_base == '0) && (y_base == '0);
        // With frame_sync the base is (0,0), so eop only fires for a 1x1 frame.
        tag_eop = (x_base == LastX) && (y_base == LastY);
        x_d     = x_base;
        y_d     = y_base;
        if (accept) begin
            if (x_base == LastX) begin
                x_d = '0;
                if (y_base == LastY) begin
                    y_d = '0;
                end else begin
                    y_d = y_base + YW'(1);
                end
            end else begin
                x_d = x_base + XW'(1);
            end
        end
    end

    // Skid-buffer steering: OUT refills from SKID first so ordering is preserved
    always_comb begin
        out_full_d  = out_full_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_sop_d  = skid_sop_q;
        skid_eop_d  = skid_eop_q;

        if (!out_full_q || send) begin
            if (skid_full_q) begin
                out_full_d = 1'b1;
                out_data_d = skid_data_q;
                out_sop_d  = skid_sop_q;
                out_eop_d  = skid_eop_q;
                if (accept) begin
                    skid_full_d = 1'b1;
                    skid_data_d = pix_data_in;
                    skid_sop_d  = tag_sop;
                    skid_eop_d  = tag_eop;
                end else begin
                    skid_full_d = 1'b0;
                end
            end else if (accept) begin
                out_full_d = 1'b1;
                out_data_d = pix_data_in;
                out_sop_d  = tag_sop;
                out_eop_d  = tag_eop;
            end else begin
                // Data and tags hold their last value; only valid drops.
                out_full_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_data_d = pix_data_in;
            skid_sop_d  = tag_sop;
            skid_eop_d  = tag_eop;
        end

        // Ready is registered: offered only while SKID will have room next cycle.
        ready_d = !skid_full_d;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            ready_q     <= 1'b0;
            out_full_q  <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_sop_q  <= 1'b0;
            skid_eop_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            ready_q     <= ready_d;
            out_full_q  <= out_full_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_sop_q  <= skid_sop_d;
            skid_eop_q  <= skid_eop_d;
        end
    end

    // Registered outputs straight from OUT and the ready flop
    always_comb begin
        pix_ready_out     = ready_q;
        valid_out         = out_full_q;
        data_out          = out_data_q;
        startofpacket_out = out_sop_q;
        endofpacket_out   = out_eop_q;
    end

endmodule

// File: tb/tb_avalon_st_source_interface.sv
// Directed self-checking bench for avalon_st_source_interface with a 4x2 frame.
module tb_avalon_st_source_interface;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FRAME_W = 4;
    localparam int unsigned FRAME_H = 2;

    logic              clk;
    logic              reset;
    logic              pix_valid_in;
    logic [DATA_W-1:0] pix_data_in;
    logic              pix_ready_out;
    logic              frame_sync;
    logic              ready_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              startofpacket_out;
    logic              endofpacket_out;

    int errors;
    int checks;

    // {valid, data, sop, eop, ready}
    logic [19:0] got;
    logic [19:0] exp;

    // Back-pressure scenario: per-cycle inputs and expected outputs
    localparam logic        BP_RDY [0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic        BP_PV  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [15:0] BP_DIN [0:6] = '{16'h0201, 16'h0202, 16'h0203, 16'h0203,
                                             16'h0203, 16'h0203, 16'h0000};
    localparam logic [19:0] BP_EXP [0:6] = '{
        {1'b1, 16'h0201, 1'b1, 1'b0, 1'b1},
        {1'b1, 16'h0201, 1'b1, 1'b0, 1'b0},
        {1'b1, 16'h0201, 1'b1, 1'b0, 1'b0},
        {1'b1, 16'h0201, 1'b1, 1'b0, 1'b0},
        {1'b1, 16'h0202, 1'b0, 1'b0, 1'b1},
        {1'b1, 16'h0203, 1'b0, 1'b0, 1'b1},
        {1'b0, 16'h0203, 1'b0, 1'b0, 1'b1}
    };

    avalon_st_source_interface #(
        .DATA_W (DATA_W),
        .FRAME_W(FRAME_W),
        .FRAME_H(FRAME_H)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pix_valid_in     (pix_valid_in),
        .pix_data_in      (pix_data_in),
        .pix_ready_out    (pix_ready_out),
        .frame_sync       (frame_sync),
        .ready_in         (ready_in),
        .valid_out        (valid_out),
        .data_out         (data_out),
        .startofpacket_out(startofpacket_out),
        .endofpacket_out  (endofpacket_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the active edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        pix_valid_in = 1'b0;
        pix_data_in  = '0;
        frame_sync   = 1'b0;
        ready_in     = 1'b0;
        #2;
        got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
        exp = 20'h0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", got, exp);
        end
        cyc();
        reset = 1'b0;
        cyc();
        got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
        exp = {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_release_ready: got %h want %h", got, exp);
        end
    endtask

    task automatic test_basic();
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pix_valid_in = 1'b1;
            pix_data_in  = 16'(i + 1);
            cyc();
            got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
            exp = {1'b1, 16'(i + 1), (i == 0), (i == 7), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_pix[%0d]: got %h want %h", i, got, exp);
            end
        end
        pix_valid_in = 1'b0;
        cyc();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_valid: got %b want 0", valid_out);
        end
    endtask

    task automatic test_frame_wrap();
        ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pix_valid_in = 1'b1;
            pix_data_in  = 16'(16'h0100 + i);
            cyc();
            got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
            exp = {1'b1, 16'(16'h0100 + i), (i == 0 || i == 8), (i == 7 || i == 15), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap_pix[%0d]: got %h want %h", i, got, exp);
            end
        end
        pix_valid_in = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 7; c++) begin
            ready_in     = BP_RDY[c];
            pix_valid_in = BP_PV[c];
            pix_data_in  = BP_DIN[c];
            cyc();
            got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
            exp = BP_EXP[c];
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL backpressure_cyc[%0d]: got %h want %h", c, got, exp);
            end
        end
    endtask

    task automatic test_frame_sync();
        // Sync without accept parks the counter at (0,0).
        ready_in     = 1'b1;
        pix_valid_in = 1'b0;
        frame_sync   = 1'b1;
        cyc();
        frame_sync = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            pix_valid_in = 1'b1;
            pix_data_in  = 16'(16'h0400 + i);
            frame_sync   = (i == 4);
            cyc();
            got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
            exp = {1'b1, 16'(16'h0400 + i), (i == 1 || i == 4 || i == 12), (i == 11), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sync_pix[%0d]: got %h want %h", i, got, exp);
            end
        end
        frame_sync   = 1'b0;
        pix_valid_in = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        ready_in = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            pix_valid_in = 1'b1;
            pix_data_in  = 16'(16'h0500 + i);
            cyc();
        end
        pix_data_in = 16'h0503;
        checks++;
        if (valid_out !== 1'b1 || data_out !== 16'h0502) begin
            errors++;
            $display("FAIL areset_pre: got v=%b d=%h want v=1 d=0502", valid_out, data_out);
        end
        // Assert reset between edges; outputs must clear immediately.
        #2;
        reset = 1'b1;
        #1;
        got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
        exp = 20'h0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL areset_immediate: got %h want %h", got, exp);
        end
        pix_valid_in = 1'b0;
        #1;
        reset = 1'b0;
        cyc();
        got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
        exp = {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL areset_release: got %h want %h", got, exp);
        end
        for (int i = 0; i < 2; i++) begin
            pix_valid_in = 1'b1;
            pix_data_in  = 16'(16'h0510 + i);
            cyc();
            got = {valid_out, data_out, startofpacket_out, endofpacket_out, pix_ready_out};
            exp = {1'b1, 16'(16'h0510 + i), (i == 0), 1'b0, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL areset_first_pix[%0d]: got %h want %h", i, got, exp);
            end
        end
        pix_valid_in = 1'b0;
        cyc();
    endtask

    task automatic test_skid_drain();
        logic [17:0] g6;
        logic [17:0] e6;
        // c1: X into OUT while stalled
        ready_in     = 1'b0;
        pix_valid_in = 1'b1;
        pix_data_in  = 16'h0601;
        cyc();
        g6 = {valid_out, data_out, pix_ready_out};
        e6 = {1'b1, 16'h0601, 1'b1};
        checks++;
        if (g6 !== e6) begin
            errors++;
            $display("FAIL skid_c1: got %h want %h", g6, e6);
        end
        // c2: Y into SKID, ready drops
        pix_data_in = 16'h0602;
        cyc();
        g6 = {valid_out, data_out, pix_ready_out};
        e6 = {1'b1, 16'h0601, 1'b0};
        checks++;
        if (g6 !== e6) begin
            errors++;
            $display("FAIL skid_c2: got %h want %h", g6, e6);
        end
        // c3: release; SKID pixel moves to OUT, Z held upstream
        ready_in    = 1'b1;
        pix_data_in = 16'h0603;
        cyc();
        g6 = {valid_out, data_out, pix_ready_out};
        e6 = {1'b1, 16'h0602, 1'b1};
        checks++;
        if (g6 !== e6) begin
            errors++;
            $display("FAIL skid_c3: got %h want %h", g6, e6);
        end
        // c4: Z follows Y
        cyc();
        g6 = {valid_out, data_out, pix_ready_out};
        e6 = {1'b1, 16'h0603, 1'b1};
        checks++;
        if (g6 !== e6) begin
            errors++;
            $display("FAIL skid_c4: got %h want %h", g6, e6);
        end
        pix_valid_in = 1'b0;
        cyc();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL skid_empty: got %b want 0", valid_out);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_frame_wrap();
        test_backpressure();
        test_frame_sync();
        test_async_reset();
        test_skid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
